// File: rtl/pla_sop_eval_seq.sv
// pla_sop_eval_seq
// Runtime-programmable single-output sum-of-products evaluator. A query vector
// is latched, then the cube table is scanned LANES cubes per cycle, lowest
// group first, stopping at the first group that contains a hit. The result
// is held until the consumer takes it. Table and polarity writes are only
// honoured while idle so a query never sees its table change mid-scan.
module pla_sop_eval_seq #(
    parameter int N_IN    = 8,
    parameter int N_CUBES = 16,
    parameter int LANES   = 4,
    localparam int IDX_W  = $clog2(N_CUBES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [N_IN-1:0]  cfg_care,
    input  logic [N_IN-1:0]  cfg_val,
    input  logic             cfg_en,
    input  logic             cfg_pol_we,
    input  logic [N_IN-1:0]  cfg_in_pol,
    input  logic             cfg_out_inv,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_y,
    output logic             out_hit,
    output logic [IDX_W-1:0] out_hit_idx,
    output logic             busy
);

    localparam int G  = N_CUBES / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    state_e           stateQ, stateD;
    logic [N_IN-1:0]  xQ, xD;
    logic [GW-1:0]    grpQ, grpD;
    logic             hitQ, hitD;
    logic [IDX_W-1:0] hitIdxQ, hitIdxD;
    logic             cfgErrQ;

    logic [N_IN-1:0]  careQ [N_CUBES];
    logic [N_IN-1:0]  valQ  [N_CUBES];
    logic [N_CUBES-1:0] enQ;
    logic [N_IN-1:0]  inPolQ;
    logic             outInvQ;

    logic             isIdle;
    logic             addrOk;
    logic             cubeWrOk;
    logic             polWrOk;
    logic [N_CUBES-1:0] cubeHit;
    logic             groupHit;
    logic [IDX_W-1:0] firstIdx;

    // The address check only matters when the table depth is not a power of two.
    assign isIdle   = (stateQ == IDLE);
    assign addrOk   = ({1'b0, cfg_addr} < (IDX_W + 1)'(N_CUBES));
    assign cubeWrOk = cfg_we && isIdle && addrOk;
    assign polWrOk  = cfg_pol_we && isIdle;

    // Cube table and polarity registers; rejected writes leave them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CUBES; c++) begin
                careQ[c] <= '0;
                valQ[c]  <= '0;
            end
            enQ     <= '0;
            inPolQ  <= '0;
            outInvQ <= 1'b0;
        end else begin
            if (cubeWrOk) begin
                careQ[cfg_addr] <= cfg_care;
                valQ[cfg_addr]  <= cfg_val;
                enQ[cfg_addr]   <= cfg_en;
            end
            if (polWrOk) begin
                inPolQ  <= cfg_in_pol;
                outInvQ <= cfg_out_inv;
            end
        end
    end

    // One-cycle error pulse for any write that arrives while busy or out of range.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfgErrQ <= 1'b0;
        end else begin
            cfgErrQ <= (cfg_we && !(isIdle && addrOk)) || (cfg_pol_we && !isIdle);
        end
    end

    // Match every cube against the latched, polarity-adjusted query vector.
    always_comb begin
        cubeHit = '0;
        for (int c = 0; c < N_CUBES; c++) begin
            cubeHit[c] = enQ[c] &&
                         ((((xQ ^ inPolQ) & careQ[c])) == (valQ[c] & careQ[c]));
        end
    end

    // Restrict to the current scan group and pick its lowest hitting index.
    always_comb begin
        groupHit = 1'b0;
        firstIdx = '0;
        for (int c = N_CUBES - 1; c >= 0; c--) begin
            if (cubeHit[c] && (GW'(c / LANES) == grpQ)) begin
                groupHit = 1'b1;
                firstIdx = IDX_W'(c);
            end
        end
    end

    // Next-state logic for the accept / scan / hold-result sequence.
    always_comb begin
        stateD  = stateQ;
        xD      = xQ;
        grpD    = grpQ;
        hitD    = hitQ;
        hitIdxD = hitIdxQ;
        case (stateQ)
            IDLE: begin
                if (in_valid) begin
                    xD     = in_x;
                    grpD   = '0;
                    stateD = SCAN;
                end
            end
            SCAN: begin
                if (groupHit) begin
                    hitD    = 1'b1;
                    hitIdxD = firstIdx;
                    stateD  = DONE;
                end else if (grpQ == GW'(G - 1)) begin
                    hitD    = 1'b0;
                    hitIdxD = '0;
                    stateD  = DONE;
                end else begin
                    grpD = grpQ + GW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateD = IDLE;
                end
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any query in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= IDLE;
            xQ      <= '0;
            grpQ    <= '0;
            hitQ    <= 1'b0;
            hitIdxQ <= '0;
        end else begin
            stateQ  <= stateD;
            xQ      <= xD;
            grpQ    <= grpD;
            hitQ    <= hitD;
            hitIdxQ <= hitIdxD;
        end
    end

    assign in_ready    = isIdle;
    assign busy        = !isIdle;
    assign out_valid   = (stateQ == DONE);
    assign out_hit     = hitQ;
    assign out_hit_idx = hitIdxQ;
    assign out_y       = hitQ ^ outInvQ;
    assign cfg_err     = cfgErrQ;

endmodule
